// File: rtl/plic_target_if.sv
// Claim/complete channel between a core and its PLIC target.
//
// Handshake: a claim is accepted on a rising edge where claim_req_i and
// claim_ready_o are both high. Exactly one cycle later claim_valid_o pulses
// for one cycle with claim_id_o. The core cannot stall the response.
// claim_id_o holds its last value while claim_valid_o is low. A request made
// while claim_ready_o is low is dropped, not queued. complete_req_i is a
// one-cycle strobe. It carries complete_id_i and needs no acknowledge.
interface plic_target_if;
  logic       claim_req_i;
  logic       claim_ready_o;
  logic       claim_valid_o;
  logic [3:0] claim_id_o;
  logic       complete_req_i;
  logic [3:0] complete_id_i;

  modport master (
    output claim_req_i, complete_req_i, complete_id_i,
    input  claim_ready_o, claim_valid_o, claim_id_o
  );

  modport slave (
    input  claim_req_i, complete_req_i, complete_id_i,
    output claim_ready_o, claim_valid_o, claim_id_o
  );
endinterface

// File: rtl/plic_target.sv
// PLIC target: picks the highest-priority pending source that is not in
// service, raises irq_o above the threshold, and runs the claim/complete
// protocol that tracks the in-service (busy) mask.
// NSRC must lie in 1..15 because source IDs are 4 bits and ID 0 is reserved.
module plic_target #(
  parameter int NSRC = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [4*NSRC-1:0] cell_id_i,
  input  logic [3*NSRC-1:0] cell_prio_i,
  input  logic [2:0]        threshold_i,
  plic_target_if.slave      bus,
  output logic              irq_o,
  output logic [NSRC-1:0]   busy_o,
  output logic [1:0]        dbg_state_o,
  output logic [3:0]        dbg_max_id_o,
  output logic [2:0]        dbg_max_prio_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP   = 2'd1,
    SETTLE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [NSRC-1:0] busy_q, busy_d, set_mask, clr_mask;
  logic [3:0]      max_id_q, win_id, claim_pick, claim_id_q;
  logic [2:0]      max_prio_q, win_prio;
  logic            irq_q, claim_valid_q, accept;

  // Arbitration: ascending scan with a strict compare, so a tie keeps the
  // lower ID.
  always_comb begin
    win_id   = 4'd0;
    win_prio = 3'd0;
    for (int k = 0; k < NSRC; k++) begin
      if (cell_id_i[4*k +: 4] != 4'd0 && cell_prio_i[3*k +: 3] != 3'd0 &&
          !busy_q[k] && cell_prio_i[3*k +: 3] > win_prio) begin
        win_id   = cell_id_i[4*k +: 4];
        win_prio = cell_prio_i[3*k +: 3];
      end
    end
  end

  // Winner and interrupt registers are refreshed every cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      max_id_q   <= 4'd0;
      max_prio_q <= 3'd0;
      irq_q      <= 1'b0;
    end else begin
      max_id_q   <= win_id;
      max_prio_q <= win_prio;
      irq_q      <= (win_prio > threshold_i);
    end
  end

  // Claim FSM next state. Only IDLE accepts. RESP and SETTLE give the winner
  // registers one full cycle to see the updated busy mask.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.claim_req_i) begin
          state_d = RESP;
          accept  = 1'b1;
        end
      end
      RESP:    state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Claim FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A claim below the threshold returns ID 0 and marks nothing busy.
  assign claim_pick = irq_q ? max_id_q : 4'd0;

  // Busy-mask update. The set term is ORed in last, so a claim beats a
  // completion of the same bit on the same edge.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (bus.complete_req_i && bus.complete_id_i == 4'(k + 1)) clr_mask[k] = 1'b1;
      if (accept && claim_pick == 4'(k + 1))                    set_mask[k] = 1'b1;
    end
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  // In-service mask register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // Response strobe and held claim ID.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      claim_valid_q <= 1'b0;
      claim_id_q    <= 4'd0;
    end else begin
      claim_valid_q <= accept;
      if (accept) claim_id_q <= claim_pick;
    end
  end

  assign bus.claim_ready_o = (state_q == IDLE);
  assign bus.claim_valid_o = claim_valid_q;
  assign bus.claim_id_o    = claim_id_q;
  assign irq_o             = irq_q;
  assign busy_o            = busy_q;
  assign dbg_state_o       = state_q;
  assign dbg_max_id_o      = max_id_q;
  assign dbg_max_prio_o    = max_prio_q;

endmodule

// File: tb/tb_plic_target.sv
// Bench for plic_target: directed scenarios plus a randomized run checked
// against a behavioural model of the arbitration and claim rules.
module tb_plic_target;
  localparam int NSRC = 8;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [4*NSRC-1:0] cell_id;
  logic [3*NSRC-1:0] cell_prio;
  logic [2:0]        threshold;
  logic              irq;
  logic [NSRC-1:0]   busy;
  logic [1:0]        dbg_state;
  logic [3:0]        dbg_max_id;
  logic [2:0]        dbg_max_prio;

  int n_cmp  = 0;
  int n_fail = 0;

  plic_target_if bus();

  plic_target #(.NSRC(NSRC)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .cell_id_i      (cell_id),
    .cell_prio_i    (cell_prio),
    .threshold_i    (threshold),
    .bus            (bus),
    .irq_o          (irq),
    .busy_o         (busy),
    .dbg_state_o    (dbg_state),
    .dbg_max_id_o   (dbg_max_id),
    .dbg_max_prio_o (dbg_max_prio)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  bit [NSRC-1:0] m_busy;
  logic [3:0]    m_max_id, m_cid;
  logic [2:0]    m_max_prio;
  bit            m_irq, m_valid;
  int            m_cool;   // cycles left before a new claim is accepted

  task automatic model_reset();
    m_busy = '0; m_max_id = 4'd0; m_max_prio = 3'd0; m_irq = 1'b0;
    m_valid = 1'b0; m_cid = 4'd0; m_cool = 0;
  endtask

  task automatic model_step();
    int best_p, best_id, id, p;
    bit acc;
    logic [3:0] new_cid;
    best_p = 0; best_id = 0; new_cid = 4'd0;
    for (int k = 0; k < NSRC; k++) begin
      id = int'(cell_id[4*k +: 4]);
      p  = int'(cell_prio[3*k +: 3]);
      if (id != 0 && p != 0 && !m_busy[k])
        if (p > best_p || (p == best_p && id < best_id)) begin
          best_p = p; best_id = id;
        end
    end
    acc = bus.claim_req_i && (m_cool == 0);
    if (acc) begin
      new_cid = m_irq ? m_max_id : 4'd0;
      m_valid = 1'b1; m_cid = new_cid; m_cool = 2;
    end else begin
      m_valid = 1'b0;
      if (m_cool > 0) m_cool--;
    end
    if (bus.complete_req_i && bus.complete_id_i >= 1 && int'(bus.complete_id_i) <= NSRC)
      m_busy[bus.complete_id_i - 1] = 1'b0;
    if (acc && new_cid != 0) m_busy[new_cid - 1] = 1'b1;
    m_max_id   = 4'(best_id);
    m_max_prio = 3'(best_p);
    m_irq      = (best_p > int'(threshold));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic clear_srcs();
    cell_id = '0; cell_prio = '0; threshold = 3'd0;
  endtask

  task automatic set_src(input int s, input int p);
    cell_id[4*(s-1) +: 4]   = 4'(s);
    cell_prio[3*(s-1) +: 3] = 3'(p);
  endtask

  task automatic claim_pulse();
    bus.claim_req_i = 1'b1;
    tick();
    bus.claim_req_i = 1'b0;
  endtask

  task automatic complete_pulse(input int id);
    bus.complete_req_i = 1'b1;
    bus.complete_id_i  = 4'(id);
    tick();
    bus.complete_req_i = 1'b0;
    bus.complete_id_i  = 4'd0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clk_idle_inputs();
    rst_i = 1'b1;
    #1;
    n_cmp++; if (bus.claim_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", bus.claim_ready_o); end
    n_cmp++; if (bus.claim_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.claim_valid_o); end
    n_cmp++; if (bus.claim_id_o !== 4'd0) begin n_fail++; $display("FAIL reset_id got=%0d exp=0", bus.claim_id_o); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
    n_cmp++; if (busy !== '0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    apply_reset();
  endtask

  task automatic clk_idle_inputs();
    clear_srcs();
    bus.claim_req_i = 1'b0; bus.complete_req_i = 1'b0; bus.complete_id_i = 4'd0;
  endtask

  task automatic test_basic_claim();
    apply_reset();
    set_src(3, 5); threshold = 3'd2;
    #1;
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL basic_irq_latency got=%b exp=0", irq); end
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL basic_irq got=%b exp=1", irq); end
    n_cmp++; if (dbg_max_id !== 4'd3) begin n_fail++; $display("FAIL basic_max_id got=%0d exp=3", dbg_max_id); end
    claim_pulse();
    n_cmp++; if (bus.claim_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", bus.claim_valid_o); end
    n_cmp++; if (bus.claim_id_o !== 4'd3) begin n_fail++; $display("FAIL basic_id got=%0d exp=3", bus.claim_id_o); end
    n_cmp++; if (busy !== 8'h04) begin n_fail++; $display("FAIL basic_busy got=%b exp=00000100", busy); end
    n_cmp++; if (bus.claim_ready_o !== 1'b0) begin n_fail++; $display("FAIL basic_ready_resp got=%b exp=0", bus.claim_ready_o); end
    tick();
    n_cmp++; if (bus.claim_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop got=%b exp=0", bus.claim_valid_o); end
    n_cmp++; if (bus.claim_id_o !== 4'd3) begin n_fail++; $display("FAIL basic_id_hold got=%0d exp=3", bus.claim_id_o); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL basic_irq_after got=%b exp=0", irq); end
    tick();
    n_cmp++; if (bus.claim_ready_o !== 1'b1) begin n_fail++; $display("FAIL basic_ready_idle got=%b exp=1", bus.claim_ready_o); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL basic_irq_idle got=%b exp=0", irq); end
  endtask

  task automatic test_tie_break();
    apply_reset();
    clear_srcs();
    set_src(2, 4); set_src(6, 4);
    tick();
    claim_pulse();
    n_cmp++; if (bus.claim_id_o !== 4'd2) begin n_fail++; $display("FAIL tie_first got=%0d exp=2", bus.claim_id_o); end
    tick(); tick();
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL tie_irq got=%b exp=1", irq); end
    n_cmp++; if (dbg_max_id !== 4'd6) begin n_fail++; $display("FAIL tie_next_winner got=%0d exp=6", dbg_max_id); end
    claim_pulse();
    n_cmp++; if (bus.claim_id_o !== 4'd6) begin n_fail++; $display("FAIL tie_second got=%0d exp=6", bus.claim_id_o); end
    n_cmp++; if (busy !== 8'h22) begin n_fail++; $display("FAIL tie_busy got=%b exp=00100010", busy); end
    tick(); tick();
  endtask

  task automatic test_threshold();
    apply_reset();
    clear_srcs();
    set_src(1, 3); threshold = 3'd3;
    tick();
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL thr_irq got=%b exp=0", irq); end
    claim_pulse();
    n_cmp++; if (bus.claim_valid_o !== 1'b1) begin n_fail++; $display("FAIL thr_valid got=%b exp=1", bus.claim_valid_o); end
    n_cmp++; if (bus.claim_id_o !== 4'd0) begin n_fail++; $display("FAIL thr_id got=%0d exp=0", bus.claim_id_o); end
    n_cmp++; if (busy !== '0) begin n_fail++; $display("FAIL thr_busy got=%b exp=0", busy); end
    tick(); tick();
  endtask

  task automatic test_complete();
    apply_reset();
    clear_srcs();
    set_src(4, 7);
    tick();
    claim_pulse();
    n_cmp++; if (bus.claim_id_o !== 4'd4) begin n_fail++; $display("FAIL cmp_claim got=%0d exp=4", bus.claim_id_o); end
    tick(); tick();
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL cmp_irq_busy got=%b exp=0", irq); end
    complete_pulse(0);
    n_cmp++; if (busy !== 8'h08) begin n_fail++; $display("FAIL cmp_id0 got=%b exp=00001000", busy); end
    complete_pulse(9);
    n_cmp++; if (busy !== 8'h08) begin n_fail++; $display("FAIL cmp_id9 got=%b exp=00001000", busy); end
    complete_pulse(2);
    n_cmp++; if (busy !== 8'h08) begin n_fail++; $display("FAIL cmp_clear_bit got=%b exp=00001000", busy); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL cmp_irq_still got=%b exp=0", irq); end
    complete_pulse(4);
    n_cmp++; if (busy !== 8'h00) begin n_fail++; $display("FAIL cmp_cleared got=%b exp=0", busy); end
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL cmp_irq_again got=%b exp=1", irq); end
  endtask

  task automatic test_back_to_back();
    int nresp, first_at, second_at;
    logic [3:0] first_id, second_id;
    nresp = 0; first_at = 0; second_at = 0; first_id = 4'd0; second_id = 4'd0;
    apply_reset();
    clear_srcs();
    set_src(5, 6); set_src(7, 6); threshold = 3'd1;
    tick();
    bus.claim_req_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_cmp++; if (bus.claim_valid_o !== m_valid) begin n_fail++; $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", i, bus.claim_valid_o, m_valid); end
      if (bus.claim_valid_o === 1'b1) begin
        nresp++;
        if (nresp == 1) begin first_at = i; first_id = bus.claim_id_o; end
        else begin second_at = i; second_id = bus.claim_id_o; end
      end
    end
    bus.claim_req_i = 1'b0;
    n_cmp++; if (nresp !== 2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", nresp); end
    n_cmp++; if (first_at !== 1 || second_at !== 4) begin n_fail++; $display("FAIL b2b_timing got=%0d,%0d exp=1,4", first_at, second_at); end
    n_cmp++; if (first_id !== 4'd5 || second_id !== 4'd7) begin n_fail++; $display("FAIL b2b_ids got=%0d,%0d exp=5,7", first_id, second_id); end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    clear_srcs();
    set_src(3, 5);
    tick();
    claim_pulse();
    n_cmp++; if (bus.claim_valid_o !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid got=%b exp=1", bus.claim_valid_o); end
    #2;
    rst_i = 1'b1;
    #1;
    n_cmp++; if (bus.claim_valid_o !== 1'b0 || bus.claim_id_o !== 4'd0) begin n_fail++; $display("FAIL rmid_resp got=%b/%0d exp=0/0", bus.claim_valid_o, bus.claim_id_o); end
    n_cmp++; if (bus.claim_ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got=%b exp=1", bus.claim_ready_o); end
    n_cmp++; if (busy !== '0 || irq !== 1'b0) begin n_fail++; $display("FAIL rmid_state got=%b/%b exp=0/0", busy, irq); end
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (bus.claim_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_no_strobe cyc=%0d got=%b exp=0", i, bus.claim_valid_o); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    clear_srcs();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0)
        for (int k = 0; k < NSRC; k++) begin
          cell_id[4*k +: 4]   = ($urandom_range(0, 2) != 0) ? 4'(k + 1) : 4'd0;
          cell_prio[3*k +: 3] = 3'($urandom_range(0, 7));
        end
      if ($urandom_range(0, 15) == 0) threshold = 3'($urandom_range(0, 7));
      bus.claim_req_i    = ($urandom_range(0, 2) == 0);
      bus.complete_req_i = ($urandom_range(0, 2) == 0);
      bus.complete_id_i  = 4'($urandom_range(0, 15));
      tick();
      n_cmp++; if (bus.claim_valid_o !== m_valid) begin n_fail++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, bus.claim_valid_o, m_valid); end
      n_cmp++; if (bus.claim_id_o !== m_cid) begin n_fail++; $display("FAIL rand_id cyc=%0d got=%0d exp=%0d", c, bus.claim_id_o, m_cid); end
      n_cmp++; if (bus.claim_ready_o !== (m_cool == 0)) begin n_fail++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, bus.claim_ready_o, (m_cool == 0)); end
      n_cmp++; if (irq !== m_irq) begin n_fail++; $display("FAIL rand_irq cyc=%0d got=%b exp=%b", c, irq, m_irq); end
      n_cmp++; if (busy !== m_busy) begin n_fail++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", c, busy, m_busy); end
      n_cmp++; if (dbg_max_id !== m_max_id || dbg_max_prio !== m_max_prio) begin n_fail++; $display("FAIL rand_winner cyc=%0d got=%0d/%0d exp=%0d/%0d", c, dbg_max_id, dbg_max_prio, m_max_id, m_max_prio); end
    end
    bus.claim_req_i = 1'b0; bus.complete_req_i = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_i = 1'b1;
    model_reset();
    test_reset();
    test_basic_claim();
    test_tie_break();
    test_threshold();
    test_complete();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/plic_target.md
PLIC_TARGET -- requirements
Module: plic_target

Interface
REQ-001 SHALL have parameter NSRC, default 8, meaning the number of plic_cell outputs consumed, with source IDs 1..NSRC and legal range 1..15.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port cell_id_i, input, 4*NSRC bits: concatenated id_o of the cells; slice k (bits 4k+3:4k) carries source ID k+1 or 0.
REQ-005 SHALL have port cell_prio_i, input, 3*NSRC bits: concatenated priority_o of the cells; slice k belongs to source k+1.
REQ-006 SHALL have port threshold_i, input, 3 bits: target priority threshold.
REQ-007 SHALL have port claim_req_i, input, 1 bit: claim request pulse from the core.
REQ-008 SHALL have port claim_ready_o, output, 1 bit: claim accepted this cycle when high.
REQ-009 SHALL have port claim_valid_o, output, 1 bit: single-cycle claim response strobe.
REQ-010 SHALL have port claim_id_o, output, 4 bits: claimed source ID, where 0 means no interrupt.
REQ-011 SHALL have port complete_req_i, input, 1 bit: completion strobe.
REQ-012 SHALL have port complete_id_i, input, 4 bits: ID being completed.
REQ-013 SHALL have port irq_o, output, 1 bit: external interrupt request to the core.
REQ-014 SHALL have port busy_o, output, NSRC bits: in-service mask, where bit k means source k+1 is claimed and not yet completed.

Function
REQ-015 SHALL treat slice k as a candidate only if its cell_id_i slice is non-zero, its prio slice is non-zero, and busy_o[k] is 0.
REQ-016 SHALL select the candidate with the highest priority; on equal priority the lowest ID wins.
REQ-017 SHALL register the winner into max_id_q (4b) and max_prio_q (3b) each cycle; if there is no candidate, both registers are 0.
REQ-018 SHALL register irq_o each cycle as (winner priority > threshold_i), strictly greater, so priority equal to threshold gives no IRQ, and priority 0 never raises an IRQ.
REQ-019 SHALL have a latency of 1 cycle from cell inputs or threshold change to max_id_q, max_prio_q and irq_o.
REQ-020 SHALL implement a claim FSM with states IDLE, RESP and SETTLE, where claim_ready_o = (state == IDLE).
REQ-021 SHALL, in IDLE with claim_req_i high, go to RESP; on that same edge set claim_valid_o = 1, set claim_id_o = irq_o ? max_id_q : 0, and set busy_o[claim_id_o-1] when claim_id_o != 0.
REQ-022 SHALL go from RESP to SETTLE unconditionally with claim_valid_o = 0; the winner is re-evaluated with the updated busy mask during this cycle.
REQ-023 SHALL go from SETTLE to IDLE unconditionally.
REQ-024 SHALL ignore claim_req_i in RESP and SETTLE; requests are not queued.
REQ-025 SHALL hold claim_id_o at its last value while claim_valid_o is low.
REQ-026 SHALL, when complete_req_i is high and 1 <= complete_id_i <= NSRC, clear busy_o[complete_id_i-1] on that edge in any FSM state.
REQ-027 SHALL ignore a completion with ID 0, ID > NSRC, or a bit that is already clear.
REQ-028 SHALL, when a claim-set and a completion-clear hit the same busy bit on the same edge, leave the bit set (set wins).
REQ-029 SHALL allow a completed source to re-enter arbitration on the cycle after the completion edge.

Reset
REQ-030 SHALL, while rst_i is high, immediately force state to IDLE and busy_o, max_id_q, max_prio_q, irq_o, claim_valid_o and claim_id_o to 0, which gives claim_ready_o = 1.
REQ-031 SHALL abandon any claim in progress when reset asserts mid-operation, with no response strobe after reset release.

Verification
REQ-032 SHALL cover: source 3 with prio 5, threshold 2 -> irq_o=1 one cycle later; claim -> claim_valid_o=1 with claim_id_o=3 next cycle, busy_o[2]=1, irq_o=0 two cycles after the response.
REQ-033 SHALL cover: sources 2 and 6 both at prio 4 -> claim returns 2; after SETTLE irq_o=1 and the next claim returns 6.
REQ-034 SHALL cover: source 1 at prio 3, threshold 3 -> irq_o=0; claim -> claim_id_o=0 and busy_o unchanged.
REQ-035 SHALL cover: claim of ID 4, then complete_id_i=4 while source 4 still asserts prio 7 -> busy_o[3] clears and irq_o=1 again 1 cycle later; complete_id_i=0 or 9 -> no change.
REQ-036 SHALL cover: claim_req_i held high for 5 cycles -> exactly two responses, on cycles 1 and 4 after the first accept.
REQ-037 SHALL cover: rst_i pulsed during RESP -> all outputs 0 and claim_ready_o=1 asynchronously, with no claim_valid_o after release.
